// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter and its pickers.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 36;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Successor index modulo n; the released owner goes to the back of the rotation.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         valid_c_o,
  output logic [W-1:0] idx_c_o
);

  always_comb begin
    int unsigned k;
    valid_c_o = 1'b0;
    idx_c_o   = '0;
    k         = 0;
    for (int unsigned j = 0; j < N; j++) begin
      k = (32'(start_i) + j) % N;
      if (!valid_c_o && req_i[W'(k)]) begin
        valid_c_o = 1'b1;
        idx_c_o   = W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one async-FIFO write port between N_REQ requesters.
// Optional macro FIFO_WR_ARB_SRC_ID_EN prepends the owner index to every written beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ  = N_REQ_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned ID_W   = $clog2(N_REQ),
`ifdef FIFO_WR_ARB_SRC_ID_EN
  localparam int unsigned WD_W   = DATA_W + ID_W
`else
  localparam int unsigned WD_W   = DATA_W
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wen,
  output logic [WD_W-1:0]         fifo_wdata,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            pick_valid_c;
  logic [ID_W-1:0] pick_idx_c;
  logic            lock_c;
  logic            fire_c;
  logic [DATA_W-1:0] owner_data_c;

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i     (req_valid),
    .start_i   (ptr_q),
    .valid_c_o (pick_valid_c),
    .idx_c_o   (pick_idx_c)
  );

  // Write path: owner's beat goes straight to the FIFO in the accept cycle.
  always_comb begin
    lock_c       = (state_q == ARB_LOCK);
    owner_data_c = req_data[32'(owner_q) * DATA_W +: DATA_W];
    req_ready    = '0;
    if (lock_c && !fifo_full) begin
      req_ready[owner_q] = 1'b1;
    end
    fire_c   = lock_c && !fifo_full && req_valid[owner_q];
    fifo_wen = fire_c;
`ifdef FIFO_WR_ARB_SRC_ID_EN
    fifo_wdata = {owner_q, owner_data_c};
`else
    fifo_wdata = owner_data_c;
`endif
  end

  // Grant is taken in IDLE and held until the owner's last beat is written.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid_c) begin
          owner_d = pick_idx_c;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (fire_c && req_last[owner_q]) begin
          state_d = ARB_IDLE;
          ptr_d   = ID_W'(rr_next(32'(owner_q), N_REQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == ARB_LOCK);
  assign grant_id = owner_q;

endmodule
